// File: rtl/rll_key_loader.sv
// rll_key_loader: serial key receiver for logic-locked netlists.
// Shifts a KEY_WIDTH-bit key plus one odd-parity bit in over a valid/ready
// handshake, retries on parity failure, and commits the key to the parallel
// key bus atomically. The bus shows either DECOY_KEY or a verified key.
module rll_key_loader #(
    parameter int                   KEY_WIDTH = 32,
    parameter logic [KEY_WIDTH-1:0] DECOY_KEY = '0,
    parameter int                   MAX_RETRY = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load_req,
    input  logic                 i_zeroize,
    input  logic                 i_s_data,
    input  logic                 i_s_valid,
    output logic                 o_s_ready,
    output logic [KEY_WIDTH-1:0] o_key_out,
    output logic                 o_key_valid,
    output logic                 o_load_err,
    output logic                 o_busy
);

    localparam int CW = $clog2(KEY_WIDTH + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    // Counter value at which the incoming beat is the parity bit
    localparam logic [CW-1:0] PARITY_BEAT = CW'(KEY_WIDTH);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_LOCKED,
        S_ERROR
    } state_t;

    state_t               r_state;
    logic [KEY_WIDTH-1:0] r_shadow;
    logic [CW-1:0]        r_cnt;
    logic                 r_parity;
    logic [RW-1:0]        r_retry;

    logic                 w_beat;
    logic [KEY_WIDTH-1:0] w_shadow_shift;

    // Beat acceptance and LSB-first shadow shift (newest bit enters at the MSB)
    always_comb begin
        w_beat                    = i_s_valid & o_s_ready;
        w_shadow_shift            = r_shadow >> 1;
        w_shadow_shift[KEY_WIDTH-1] = i_s_data;
    end

    // Loader FSM: all outputs are registered alongside the state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_shadow    <= '0;
            r_cnt       <= '0;
            r_parity    <= 1'b0;
            r_retry     <= '0;
            o_s_ready   <= 1'b0;
            o_key_out   <= DECOY_KEY;
            o_key_valid <= 1'b0;
            o_load_err  <= 1'b0;
            o_busy      <= 1'b0;
        end else if (i_zeroize) begin
            // Erase wins over any load, beat or commit; the error flag survives
            r_state     <= S_IDLE;
            r_shadow    <= '0;
            r_cnt       <= '0;
            r_parity    <= 1'b0;
            r_retry     <= '0;
            o_s_ready   <= 1'b0;
            o_key_out   <= DECOY_KEY;
            o_key_valid <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_load_req) begin
                        r_state   <= S_SHIFT;
                        r_shadow  <= '0;
                        r_cnt     <= '0;
                        r_parity  <= 1'b0;
                        r_retry   <= '0;
                        o_s_ready <= 1'b1;
                        o_busy    <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_beat) begin
                        r_parity <= r_parity ^ i_s_data;
                        if (r_cnt == PARITY_BEAT) begin
                            // Parity bit does not enter the shadow
                            r_state   <= S_CHECK;
                            o_s_ready <= 1'b0;
                        end else begin
                            r_shadow <= w_shadow_shift;
                            r_cnt    <= r_cnt + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (r_parity) begin
                        r_state     <= S_LOCKED;
                        o_key_out   <= r_shadow;
                        o_key_valid <= 1'b1;
                        o_busy      <= 1'b0;
                    end else if (r_retry < RETRY_LIMIT) begin
                        r_state   <= S_SHIFT;
                        r_retry   <= r_retry + 1'b1;
                        r_shadow  <= '0;
                        r_cnt     <= '0;
                        r_parity  <= 1'b0;
                        o_s_ready <= 1'b1;
                    end else begin
                        r_state     <= S_ERROR;
                        o_load_err  <= 1'b1;
                        o_key_out   <= DECOY_KEY;
                        o_key_valid <= 1'b0;
                        o_busy      <= 1'b0;
                    end
                end
                S_LOCKED: begin
                    // Write-once: hold the committed key until zeroize or reset
                    r_state <= S_LOCKED;
                end
                S_ERROR: begin
                    r_state     <= S_ERROR;
                    o_key_out   <= DECOY_KEY;
                    o_key_valid <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    o_s_ready   <= 1'b0;
                    o_busy      <= 1'b0;
                    o_key_out   <= DECOY_KEY;
                    o_key_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rll_key_loader.sv
// Bench for rll_key_loader: table-driven loads, randomized loads with gaps
// against an outcome-level reference model, and hand-written corner cases.
module tb_rll_key_loader;

    localparam int KW        = 32;
    localparam int MAX_RETRY = 2;
    localparam logic [KW-1:0] DECOY = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_req;
    logic          zeroize;
    logic          s_data;
    logic          s_valid;
    logic          s_ready;
    logic [KW-1:0] key_out;
    logic          key_valid;
    logic          load_err;
    logic          busy;

    int nvec = 0;
    int nerr = 0;

    rll_key_loader #(.KEY_WIDTH(KW), .DECOY_KEY(DECOY), .MAX_RETRY(MAX_RETRY)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load_req  (load_req),
        .i_zeroize   (zeroize),
        .i_s_data    (s_data),
        .i_s_valid   (s_valid),
        .o_s_ready   (s_ready),
        .o_key_out   (key_out),
        .o_key_valid (key_valid),
        .o_load_err  (load_err),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [KW-1:0] key;
        int            nbad;
        logic [KW-1:0] exp_key;
        logic          exp_valid;
        logic          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic sr, input logic [KW-1:0] k,
                           input logic kv, input logic er, input logic bz);
        chk({name, ".s_ready"},   64'(s_ready),   64'(sr));
        chk({name, ".key_out"},   64'(key_out),   64'(k));
        chk({name, ".key_valid"}, 64'(key_valid), 64'(kv));
        chk({name, ".load_err"},  64'(load_err),  64'(er));
        chk({name, ".busy"},      64'(busy),      64'(bz));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Frame = {parity, key}; good parity makes the XOR of all 33 bits equal 1
    function automatic logic [KW:0] mk_frame(input logic [KW-1:0] k, input bit good);
        logic p;
        p = good ? ~(^k) : (^k);
        return {p, k};
    endfunction

    // Reference: first good frame within MAX_RETRY+1 attempts commits, else error
    task automatic model(input logic [KW-1:0] k, input int nbad,
                         output logic [KW-1:0] ek, output logic ev, output logic ee);
        bit good_q[$];
        for (int i = 0; i < nbad; i++) good_q.push_back(1'b0);
        good_q.push_back(1'b1);
        ek = DECOY; ev = 1'b0; ee = 1'b1;
        for (int a = 0; a <= MAX_RETRY && a < good_q.size(); a++) begin
            if (good_q[a]) begin
                ek = k; ev = 1'b1; ee = 1'b0;
                break;
            end
        end
    endtask

    // Asserts rst between edges and checks the outputs before any edge arrives
    task automatic do_reset(input string name);
        rst = 1'b1; load_req = 1'b0; zeroize = 1'b0; s_valid = 1'b0; s_data = 1'b0;
        #2;
        chk_out(name, 1'b0, DECOY, 1'b0, 1'b0, 1'b0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic start_load;
        load_req = 1'b1;
        tick;
        load_req = 1'b0;
    endtask

    // Send nbits of a frame, with random idle gaps and optional load_req noise
    task automatic send_bits(input logic [KW:0] frame, input int nbits,
                             input int gapmax, input bit noise);
        int g;
        for (int i = 0; i < nbits; i++) begin
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            for (int j = 0; j < g; j++) begin
                s_valid  = 1'b0;
                s_data   = 1'($urandom);
                load_req = noise && ($urandom_range(0, 3) == 0);
                tick;
            end
            s_valid  = 1'b1;
            s_data   = frame[i];
            load_req = noise && ($urandom_range(0, 3) == 0);
            tick;
        end
        s_valid  = 1'b0;
        load_req = 1'b0;
    endtask

    // Full load: nbad bad frames (junk keys) then a good frame if attempts remain
    task automatic run_load(input logic [KW-1:0] k, input int nbad,
                            input int gapmax, input bit noise);
        start_load;
        chk_out("load_start", 1'b1, DECOY, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < nbad && b <= MAX_RETRY; b++) begin
            send_bits(mk_frame(KW'($urandom), 1'b0), KW + 1, gapmax, noise);
            chk_out("bad_check_cycle", 1'b0, DECOY, 1'b0, 1'b0, 1'b1);
            tick;
            if (b < MAX_RETRY)
                chk_out("retry_ready", 1'b1, DECOY, 1'b0, 1'b0, 1'b1);
            else
                chk_out("retry_exhausted", 1'b0, DECOY, 1'b0, 1'b1, 1'b0);
        end
        if (nbad <= MAX_RETRY) begin
            send_bits(mk_frame(k, 1'b1), KW + 1, gapmax, noise);
            chk_out("good_check_cycle", 1'b0, DECOY, 1'b0, 1'b0, 1'b1);
            tick;
        end
    endtask

    // In LOCKED or ERROR, load_req and data beats must change nothing
    task automatic poke_ignored(input string name, input logic [KW-1:0] ek,
                                input logic ev, input logic ee);
        load_req = 1'b1;
        s_valid  = 1'b1;
        s_data   = 1'b1;
        repeat (3) tick;
        load_req = 1'b0;
        s_valid  = 1'b0;
        tick;
        chk_out(name, 1'b0, ek, ev, ee, 1'b0);
    endtask

    vec_t          tbl[5];
    logic [KW-1:0] ek;
    logic          ev;
    logic          ee;
    logic [KW-1:0] rk;
    int            rb;

    initial begin
        tbl[0] = '{key: 32'hA5C3_0F96, nbad: 0, exp_key: 32'hA5C3_0F96, exp_valid: 1'b1, exp_err: 1'b0};
        tbl[1] = '{key: 32'hA5C3_0F96, nbad: 1, exp_key: 32'hA5C3_0F96, exp_valid: 1'b1, exp_err: 1'b0};
        tbl[2] = '{key: 32'h0000_0000, nbad: 2, exp_key: 32'h0000_0000, exp_valid: 1'b1, exp_err: 1'b0};
        tbl[3] = '{key: 32'hFFFF_FFFF, nbad: 0, exp_key: 32'hFFFF_FFFF, exp_valid: 1'b1, exp_err: 1'b0};
        tbl[4] = '{key: 32'h1234_5678, nbad: 3, exp_key: 32'h0000_0000, exp_valid: 1'b0, exp_err: 1'b1};

        rst = 1'b1; load_req = 1'b0; zeroize = 1'b0; s_valid = 1'b0; s_data = 1'b0;

        // Spec-given parity bit for the reference key is 1
        chk("ref_key_parity_bit", 64'(mk_frame(32'hA5C3_0F96, 1'b1) >> KW), 64'd1);

        // Table-driven loads, continuous s_valid
        for (int t = 0; t < 5; t++) begin
            do_reset("tbl_reset");
            run_load(tbl[t].key, tbl[t].nbad, 0, 1'b0);
            chk_out($sformatf("tbl%0d_final", t), 1'b0, tbl[t].exp_key,
                    tbl[t].exp_valid, tbl[t].exp_err, 1'b0);
            poke_ignored($sformatf("tbl%0d_ignored", t), tbl[t].exp_key,
                         tbl[t].exp_valid, tbl[t].exp_err);
        end

        // Randomized loads with gaps and mid-frame load_req noise
        for (int r = 0; r < 16; r++) begin
            rk = (r < 4) ? 32'hA5C3_0F96 : KW'($urandom);
            rb = int'($urandom_range(0, 3));
            model(rk, rb, ek, ev, ee);
            do_reset("rnd_reset");
            run_load(rk, rb, 5, 1'b1);
            chk_out($sformatf("rnd%0d_final", r), 1'b0, ek, ev, ee, 1'b0);
        end

        // Zeroize mid-frame after 10 bits, then a fresh load
        do_reset("zmid_reset");
        start_load;
        send_bits(mk_frame(32'hDEAD_BEEF, 1'b1), 10, 0, 1'b0);
        zeroize = 1'b1;
        tick;
        zeroize = 1'b0;
        chk_out("zeroize_midframe", 1'b0, DECOY, 1'b0, 1'b0, 1'b0);
        run_load(32'hA5C3_0F96, 0, 0, 1'b0);
        chk_out("load_after_zeroize", 1'b0, 32'hA5C3_0F96, 1'b1, 1'b0, 1'b0);

        // Zeroize in LOCKED
        zeroize = 1'b1;
        tick;
        zeroize = 1'b0;
        chk_out("zeroize_locked", 1'b0, DECOY, 1'b0, 1'b0, 1'b0);

        // Zeroize coincident with the CHECK commit
        do_reset("zcommit_reset");
        start_load;
        send_bits(mk_frame(32'h0F0F_1234, 1'b1), KW + 1, 0, 1'b0);
        zeroize = 1'b1;
        tick;
        zeroize = 1'b0;
        chk_out("zeroize_at_commit", 1'b0, DECOY, 1'b0, 1'b0, 1'b0);
        tick;
        chk_out("zeroize_at_commit_hold", 1'b0, DECOY, 1'b0, 1'b0, 1'b0);

        // Error state: zeroize keeps load_err, only rst clears it
        do_reset("err_reset");
        run_load(32'h1111_2222, 3, 0, 1'b0);
        zeroize = 1'b1;
        tick;
        zeroize = 1'b0;
        chk_out("err_after_zeroize", 1'b0, DECOY, 1'b0, 1'b1, 1'b0);
        do_reset("err_cleared_by_rst");

        // Async reset mid-frame at bit 20, checked before the next edge
        start_load;
        send_bits(mk_frame(32'hCAFE_F00D, 1'b1), 20, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst_shift", 1'b0, DECOY, 1'b0, 1'b0, 1'b0);
        tick;
        rst = 1'b0;
        run_load(32'h5A5A_C3C3, 0, 0, 1'b0);
        chk_out("clean_after_rst", 1'b0, 32'h5A5A_C3C3, 1'b1, 1'b0, 1'b0);

        // Async reset in LOCKED
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst_locked", 1'b0, DECOY, 1'b0, 1'b0, 1'b0);
        tick;
        rst = 1'b0;
        run_load(32'hA5C3_0F96, 0, 0, 1'b0);
        chk_out("reload_after_rst", 1'b0, 32'hA5C3_0F96, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
